zigzag_encryption: RTL and testbench
====================================

ZIGZAG_ENCRYPTION -- requirements
Module: zigzag_encryption

Interface
REQ-001 SHALL have parameter D_WIDTH, default 8, width of data characters.
REQ-002 SHALL have parameter KEY_WIDTH, default 8, width of key.
REQ-003 SHALL have parameter MAX_NOF_CHARS, default 50, maximum message length in characters.
REQ-004 SHALL have parameter START_ENCRYPTION_TOKEN, default 8'hFA, end-of-message / start-encryption marker.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have port data_i  input  D_WIDTH  plaintext character.
REQ-008 SHALL have port valid_i  input  1  data_i qualifier.
REQ-009 SHALL have port key  input  KEY_WIDTH  number of zigzag rails.
REQ-010 SHALL have port data_o  output  D_WIDTH  ciphertext character, registered.
REQ-011 SHALL have port valid_o  output  1  data_o qualifier, registered.
REQ-012 SHALL have port busy  output  1  high while ciphertext is emitted, registered.

Function
REQ-013 SHALL implement two states: COLLECT (busy=0) and EMIT (busy=1).
REQ-014 In COLLECT, valid_i=1 with data_i != token SHALL store data_i at index N and increment count N on that edge.
REQ-015 In COLLECT, characters arriving when N = MAX_NOF_CHARS SHALL be dropped; N saturates.
REQ-016 In COLLECT, valid_i=1 with data_i == token SHALL latch key, set busy=1, and enter EMIT on that edge; the token is not stored.
REQ-017 In EMIT, valid_i and data_i SHALL be ignored, tokens included.
REQ-018 In EMIT, one character SHALL be emitted per cycle; valid_o=1 on the N edges following the token edge, with no gaps.
REQ-019 Latched key==2: SHALL emit even-indexed characters ascending, then odd-indexed characters ascending.
REQ-020 Latched key==3: SHALL emit indices i mod 4==0, then i odd, then i mod 4==2, each group ascending.
REQ-021 Any other latched key: SHALL emit characters in original order (identity).
REQ-022 Output index generation SHALL use counters and rail strides only (stride 2 for key 2; 4/2/4 for key 3), with no division; a rail whose start index is >= N SHALL be skipped without a bubble.
REQ-023 On the edge after the Nth output, valid_o SHALL drop to 0, busy SHALL drop to 0, N SHALL clear, and the block SHALL return to COLLECT; data_o holds its last value.
REQ-024 Token with N=0: busy SHALL be 1 for exactly one cycle, and valid_o SHALL stay 0.
REQ-025 A character or token presented on the same edge that busy falls SHALL be ignored; acceptance resumes on the next edge.
REQ-026 data_o SHALL be don't-care but stable when valid_o=0.

Reset
REQ-027 rst_n=0 SHALL asynchronously force data_o=0, valid_o=0, busy=0, N=0, state=COLLECT, and clear all indices and the latched key.
REQ-028 Reset asserted mid-EMIT SHALL abort output immediately; no further valid_o until a new message is collected.
REQ-029 Buffer contents need not be cleared by reset; N=0 makes them unreachable.

Verification
REQ-030 key=2, send 41,42,43,44,45,FA -> valid_o for 5 consecutive cycles, data_o = 41,43,45,42,44; busy then drops.
REQ-031 key=3, send 41..47 (A..G),FA -> data_o = 41,45,42,44,46,43,47.
REQ-032 key=3, send 41,42,FA -> data_o = 41,42 (third rail empty, no bubble); key=1, send 41,42,43,FA -> 41,42,43.
REQ-033 Send FA alone -> busy high 1 cycle, valid_o never asserted; key changed during EMIT -> output order unaffected.
REQ-034 Send 52 chars then FA (key=2) -> exactly 50 outputs covering the first 50 chars; FA sent during EMIT -> ignored.
REQ-035 Assert rst_n=0 between clock edges mid-EMIT -> outputs 0 immediately; after release, a new 3-char message encrypts correctly.

Source files
------------

// File: rtl/zigzag_encryption.sv
// zigzag_encryption
//   Collects a plaintext message character by character, then emits it
//   reordered as a rail-fence ("zigzag") cipher once the start token arrives.
//
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   data_i  in   [D_WIDTH]    plaintext character
//   valid_i in   data_i qualifier
//   key     in   [KEY_WIDTH]  number of rails (2 or 3, anything else = identity)
//   data_o  out  [D_WIDTH]    ciphertext character (registered)
//   valid_o out  data_o qualifier (registered)
//   busy    out  high while the ciphertext is being emitted (registered)
module zigzag_encryption #(
    parameter int                 D_WIDTH                = 8,
    parameter int                 KEY_WIDTH              = 8,
    parameter int                 MAX_NOF_CHARS          = 50,
    parameter logic [D_WIDTH-1:0] START_ENCRYPTION_TOKEN = 8'hFA
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [D_WIDTH-1:0]   data_i,
    input  logic                 valid_i,
    input  logic [KEY_WIDTH-1:0] key,
    output logic [D_WIDTH-1:0]   data_o,
    output logic                 valid_o,
    output logic                 busy
);

    // Index width leaves headroom for idx + 4 without wrapping.
    localparam int IDX_W  = $clog2(MAX_NOF_CHARS + 5);
    localparam int ADDR_W = (MAX_NOF_CHARS > 1) ? $clog2(MAX_NOF_CHARS) : 1;

    typedef enum logic {
        COLLECT,
        EMIT
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     count_q, count_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     out_cnt_q, out_cnt_d;
    logic [1:0]           rail_q, rail_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic [D_WIDTH-1:0]   data_o_q, data_o_d;
    logic                 valid_o_q, valid_o_d;
    logic                 busy_q, busy_d;

    logic                 wr_en;
    logic                 is_token;
    logic                 is_k2, is_k3;
    logic [1:0]           nof_rails;
    logic [IDX_W-1:0]     stride;

    // Message buffer: deliberately not reset, count_q=0 hides stale entries.
    logic [D_WIDTH-1:0]   mem [MAX_NOF_CHARS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[count_q[ADDR_W-1:0]] <= data_i;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= COLLECT;
            count_q   <= '0;
            idx_q     <= '0;
            out_cnt_q <= '0;
            rail_q    <= '0;
            key_q     <= '0;
            data_o_q  <= '0;
            valid_o_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            out_cnt_q <= out_cnt_d;
            rail_q    <= rail_d;
            key_q     <= key_d;
            data_o_q  <= data_o_d;
            valid_o_q <= valid_o_d;
            busy_q    <= busy_d;
        end
    end

    assign is_token = (data_i == START_ENCRYPTION_TOKEN);

    // Rail geometry: rail r starts at index r; key 2 strides 2/2,
    // key 3 strides 4/2/4, identity is one rail of stride 1.
    always_comb begin
        is_k2     = (key_q == KEY_WIDTH'(2));
        is_k3     = (key_q == KEY_WIDTH'(3));
        nof_rails = is_k2 ? 2'd2 : (is_k3 ? 2'd3 : 2'd1);
        if (is_k2) begin
            stride = IDX_W'(2);
        end else if (is_k3) begin
            stride = (rail_q == 2'd1) ? IDX_W'(2) : IDX_W'(4);
        end else begin
            stride = IDX_W'(1);
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            COLLECT: if (valid_i && is_token) state_d = EMIT;
            EMIT:    if (out_cnt_q == count_q) state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // Output and datapath logic
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] next_idx;

        found     = 1'b0;
        next_idx  = idx_q + stride;
        count_d   = count_q;
        idx_d     = idx_q;
        out_cnt_d = out_cnt_q;
        rail_d    = rail_q;
        key_d     = key_q;
        data_o_d  = data_o_q;
        valid_o_d = 1'b0;
        busy_d    = busy_q;
        wr_en     = 1'b0;

        unique case (state_q)
            COLLECT: begin
                if (valid_i) begin
                    if (is_token) begin
                        key_d     = key;
                        idx_d     = '0;
                        rail_d    = '0;
                        out_cnt_d = '0;
                        busy_d    = 1'b1;
                    end else if (count_q < IDX_W'(MAX_NOF_CHARS)) begin
                        wr_en   = 1'b1;
                        count_d = count_q + IDX_W'(1);
                    end
                end
            end
            EMIT: begin
                if (out_cnt_q == count_q) begin
                    busy_d  = 1'b0;
                    count_d = '0;
                end else begin
                    data_o_d  = mem[idx_q[ADDR_W-1:0]];
                    valid_o_d = 1'b1;
                    out_cnt_d = out_cnt_q + IDX_W'(1);
                    if (next_idx < count_q) begin
                        idx_d = next_idx;
                    end else begin
                        // Jump straight to the first later rail whose start
                        // index lies inside the message, so empty rails cost
                        // no cycle.
                        for (int unsigned r = 1; r < 3; r++) begin
                            if (!found && (2'(r) > rail_q) && (2'(r) < nof_rails)
                                && (IDX_W'(r) < count_q)) begin
                                found  = 1'b1;
                                rail_d = 2'(r);
                                idx_d  = IDX_W'(r);
                            end
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    assign data_o  = data_o_q;
    assign valid_o = valid_o_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_zigzag_encryption.sv
// tb_zigzag_encryption
//   Self-checking bench for zigzag_encryption: directed messages plus
//   randomized messages, compared against a modulo-based reference ordering.
module tb_zigzag_encryption;

    localparam int         MAXC = 50;
    localparam logic [7:0] TOK  = 8'hFA;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_i;
    logic       valid_i;
    logic [7:0] key;
    logic [7:0] data_o;
    logic       valid_o;
    logic       busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] msg_q[$];
    logic [7:0] exp_q[$];

    zigzag_encryption #(
        .D_WIDTH               (8),
        .KEY_WIDTH             (8),
        .MAX_NOF_CHARS         (MAXC),
        .START_ENCRYPTION_TOKEN(TOK)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .data_i (data_i),
        .valid_i(valid_i),
        .key    (key),
        .data_o (data_o),
        .valid_o(valid_o),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference ordering from the rail rules, using plain modulo arithmetic.
    task automatic build_expected(input int k);
        int n;
        n = (msg_q.size() > MAXC) ? MAXC : msg_q.size();
        exp_q.delete();
        if (k == 2) begin
            for (int i = 0; i < n; i++) if (i % 2 == 0) exp_q.push_back(msg_q[i]);
            for (int i = 0; i < n; i++) if (i % 2 == 1) exp_q.push_back(msg_q[i]);
        end else if (k == 3) begin
            for (int i = 0; i < n; i++) if (i % 4 == 0) exp_q.push_back(msg_q[i]);
            for (int i = 0; i < n; i++) if (i % 2 == 1) exp_q.push_back(msg_q[i]);
            for (int i = 0; i < n; i++) if (i % 4 == 2) exp_q.push_back(msg_q[i]);
        end else begin
            for (int i = 0; i < n; i++) exp_q.push_back(msg_q[i]);
        end
    endtask

    // Random traffic during EMIT (tokens included) that must be ignored.
    task automatic drive_junk();
        valid_i = 1'($urandom_range(0, 1));
        data_i  = ($urandom_range(0, 2) == 0) ? TOK : 8'($urandom);
        key     = 8'($urandom);
    endtask

    task automatic run_msg(input string name, input int k);
        build_expected(k);
        foreach (msg_q[i]) begin
            @(negedge clk);
            valid_i = 1'b1;
            data_i  = msg_q[i];
            key     = 8'($urandom);
        end
        @(negedge clk);
        valid_i = 1'b1;
        data_i  = TOK;
        key     = 8'(k);
        @(negedge clk);
        check($sformatf("%s busy_after_token", name), 32'(busy), 32'd1);
        check($sformatf("%s valid_after_token", name), 32'(valid_o), 32'd0);
        drive_junk();
        for (int j = 0; j < exp_q.size(); j++) begin
            @(negedge clk);
            check($sformatf("%s valid[%0d]", name, j), 32'(valid_o), 32'd1);
            check($sformatf("%s data[%0d]", name, j), 32'(data_o), 32'(exp_q[j]));
            check($sformatf("%s busy[%0d]", name, j), 32'(busy), 32'd1);
            drive_junk();
        end
        @(negedge clk);
        check($sformatf("%s valid_end", name), 32'(valid_o), 32'd0);
        check($sformatf("%s busy_end", name), 32'(busy), 32'd0);
        if (exp_q.size() > 0)
            check($sformatf("%s data_hold", name), 32'(data_o), 32'(exp_q[exp_q.size()-1]));
        valid_i = 1'b0;
    endtask

    initial begin
        int n;
        int k;
        rst_n   = 1'b0;
        valid_i = 1'b0;
        data_i  = '0;
        key     = '0;
        repeat (3) @(negedge clk);
        check("reset data_o", 32'(data_o), 32'd0);
        check("reset valid_o", 32'(valid_o), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        msg_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
        run_msg("k2_five", 2);
        msg_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47};
        run_msg("k3_seven", 3);
        msg_q = '{8'h41, 8'h42};
        run_msg("k3_two", 3);
        msg_q = '{8'h41, 8'h42, 8'h43};
        run_msg("k1_three", 1);
        msg_q.delete();
        run_msg("token_alone", 2);

        msg_q.delete();
        for (int i = 0; i < 52; i++) msg_q.push_back(8'($urandom_range(0, 8'hF9)));
        run_msg("k2_overflow", 2);

        // Asynchronous reset in the middle of emission.
        msg_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        foreach (msg_q[i]) begin
            @(negedge clk);
            valid_i = 1'b1;
            data_i  = msg_q[i];
        end
        @(negedge clk);
        data_i = TOK;
        key    = 8'd2;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset valid", 32'(valid_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset data_o", 32'(data_o), 32'd0);
        check("async_reset valid_o", 32'(valid_o), 32'd0);
        check("async_reset busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("post_reset quiet[%0d]", i), 32'(valid_o), 32'd0);
        end
        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg("after_reset_k2", 2);

        for (int t = 0; t < 10; t++) begin
            n = $urandom_range(0, 14);
            k = $urandom_range(0, 5);
            msg_q.delete();
            for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom_range(0, 8'hF9)));
            run_msg($sformatf("rand%0d_k%0d_n%0d", t, k, n), k);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
